// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and memory-side signals of the instruction memory arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters and memory.
interface imem_arbiter_if #(
    parameter int unsigned AW = 9
);
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_flush;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;

    logic          l_req;
    logic          l_we;
    logic          l_lock;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;

    logic          err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req, f_addr, f_flush,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, f_flush,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-port instruction memory between fetch and loader,
// with loader burst locking, a lock-length starvation guard and response steering.
module imem_arbiter #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned AW       = 9,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic clk,
    input  logic rst,
    imem_arbiter_if.slave bus
);
    localparam int unsigned CW        = $clog2(MAX_LOCK + 1);
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic {RR_FETCH, RR_LOADER} side_t;

    state_t        state, state_nx;
    side_t         rr_last, rr_last_nx;
    logic [CW-1:0] lock_cnt, lock_cnt_nx;
    logic          relock_block, relock_block_nx;

    logic          f_gnt_i, l_gnt_i;
    logic          f_bad, l_bad;

    logic          f_pend, l_pend, bad_pend, flush_pend;
    logic [31:0]   f_hold, l_hold;
    logic [31:0]   f_resp, l_resp;

    // Misaligned or beyond the populated depth.
    function automatic logic is_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= 32'(DEPTH));
    endfunction

    assign f_bad = is_bad(bus.f_addr);
    assign l_bad = is_bad(bus.l_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_last      <= RR_LOADER;
            lock_cnt     <= '0;
            relock_block <= 1'b0;
        end else begin
            state        <= state_nx;
            rr_last      <= rr_last_nx;
            lock_cnt     <= lock_cnt_nx;
            relock_block <= relock_block_nx;
        end
    end

    // Arbitration and lock control; nothing is granted while reset is held.
    always_comb begin
        state_nx        = state;
        rr_last_nx      = rr_last;
        lock_cnt_nx     = lock_cnt;
        relock_block_nx = relock_block;
        f_gnt_i         = 1'b0;
        l_gnt_i         = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (bus.f_req && bus.l_req) begin
                        f_gnt_i = (rr_last == RR_LOADER);
                        l_gnt_i = (rr_last == RR_FETCH);
                    end else begin
                        f_gnt_i = bus.f_req;
                        l_gnt_i = bus.l_req;
                    end
                    if (f_gnt_i) rr_last_nx = RR_FETCH;
                    if (l_gnt_i) rr_last_nx = RR_LOADER;
                    if (l_gnt_i && bus.l_lock && !relock_block) begin
                        state_nx    = LOCKED;
                        lock_cnt_nx = CW'(1);
                    end
                    // A served or absent fetch lifts the post-starvation re-lock ban.
                    if (f_gnt_i || !bus.f_req) relock_block_nx = 1'b0;
                end
                LOCKED: begin
                    l_gnt_i     = bus.l_req;
                    lock_cnt_nx = lock_cnt + CW'(1);
                    if (l_gnt_i) rr_last_nx = RR_LOADER;
                    if (!bus.l_lock) begin
                        state_nx    = IDLE;
                        lock_cnt_nx = '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state_nx        = IDLE;
                        lock_cnt_nx     = '0;
                        rr_last_nx      = RR_LOADER;
                        relock_block_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.f_gnt = f_gnt_i;
    assign bus.l_gnt = l_gnt_i;

    // Memory drive: bad accesses are granted but never reach the array.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (f_gnt_i) begin
            bus.mem_en   = !f_bad;
            bus.mem_addr = bus.f_addr[AW+1:2];
        end else if (l_gnt_i) begin
            bus.mem_en    = !l_bad;
            bus.mem_we    = bus.l_we && !l_bad;
            bus.mem_addr  = bus.l_addr[AW+1:2];
            bus.mem_wdata = bus.l_wdata;
        end
    end

    // Ownership of the one-cycle-late read data plus the held response values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_pend     <= 1'b0;
            l_pend     <= 1'b0;
            bad_pend   <= 1'b0;
            flush_pend <= 1'b0;
            bus.err    <= 1'b0;
            f_hold     <= '0;
            l_hold     <= '0;
        end else begin
            f_pend     <= f_gnt_i;
            l_pend     <= l_gnt_i && !bus.l_we;
            bad_pend   <= f_gnt_i ? f_bad : l_bad;
            flush_pend <= f_gnt_i && bus.f_flush;
            bus.err    <= (f_gnt_i && f_bad) || (l_gnt_i && l_bad);
            if (f_pend) f_hold <= f_resp;
            if (l_pend) l_hold <= l_resp;
        end
    end

    assign f_resp = (flush_pend || bus.f_flush) ? NOP_WORD :
                    (bad_pend ? 32'h0 : bus.mem_rdata);
    assign l_resp = bad_pend ? 32'h0 : bus.mem_rdata;

    assign bus.f_rvalid = f_pend;
    assign bus.f_rdata  = f_pend ? f_resp : f_hold;
    assign bus.l_rvalid = l_pend;
    assign bus.l_rdata  = l_pend ? l_resp : l_hold;
endmodule
